muldiv_issue_sched: RTL and testbench

- Round-robin issue scheduler that shares the core's single iterative multiply/divide unit between reservation-station requesters.
- Grants one requester at a time, tracks the in-flight op with a latency counter, and returns the completion tag to the CDB-write logic.
- Sits between the mult/div reservation stations and the mult/div execution unit in the out-of-order pipeline.

---
 rtl/muldiv_sched_pkg.sv | 24 ++
 rtl/muldiv_issue_sched_rr_arbiter.sv | 33 +++
 rtl/muldiv_issue_sched.sv | 139 +++++++++++++
 tb/tb_muldiv_issue_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared types and default latencies for the mult/div issue scheduler.
package muldiv_sched_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_TAG_W    = 5;
    localparam int DEF_MULT_LAT = 3;
    localparam int DEF_DIV_LAT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grant_o = '0;
        idx_o   = '0;
        pos     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/muldiv_issue_sched.sv
// Round-robin issue scheduler for the shared iterative mult/div unit.
// Optional perf counters are built when MULDIV_SCHED_PERF_EN is defined.
module muldiv_issue_sched
    import muldiv_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_div,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     issue_valid,
    output logic                     issue_div,
    output logic [TAG_W-1:0]         issue_tag,
    output logic                     unit_busy,
    output logic                     done_valid,
    output logic                     done_div,
    output logic [TAG_W-1:0]         done_tag,
    output logic [31:0]              perf_busy,
    output logic [31:0]              perf_stall
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(max_int(MULT_LAT, DIV_LAT));

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    op_t               op_q, op_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               grant_ok;
    logic               win_div;
    logic [TAG_W-1:0]   win_tag;
    logic [CNT_W-1:0]   lat_m1;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Reset is folded in so grant/issue read zero while reset is held.
    assign grant_ok = !reset && (state_q != RUN) && arb_any && !flush;
    assign win_div  = req_div[arb_idx];
    assign win_tag  = req_tag[arb_idx*TAG_W +: TAG_W];
    assign lat_m1   = win_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_ok) state_d = RUN;
            RUN:     if (flush) state_d = IDLE;
                     else if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = grant_ok ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        rr_d  = rr_q;
        tag_d = tag_q;
        op_d  = op_q;
        if (grant_ok) begin
            cnt_d = lat_m1;
            rr_d  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            tag_d = win_tag;
            op_d  = win_div ? OP_DIV : OP_MUL;
        end else if (state_q == RUN) begin
            cnt_d = flush ? '0 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            rr_q  <= '0;
            tag_q <= '0;
            op_q  <= OP_MUL;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            tag_q <= tag_d;
            op_q  <= op_d;
        end
    end

    always_comb begin
        grant       = grant_ok ? arb_grant : '0;
        issue_valid = grant_ok;
        issue_div   = grant_ok && win_div;
        issue_tag   = grant_ok ? win_tag : '0;
        unit_busy   = (state_q == RUN);
        done_valid  = (state_q == DONE) && !flush;
        done_div    = done_valid && (op_q == OP_DIV);
        done_tag    = done_valid ? tag_q : '0;
    end

`ifdef MULDIV_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == RUN && perf_busy_q != '1)
                perf_busy_q <= perf_busy_q + 32'd1;
            if (state_q == RUN && |req_valid && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_muldiv_issue_sched.sv
// Self-checking bench for muldiv_issue_sched against a cycle-level op-tracking model.
module tb_muldiv_issue_sched;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int ML = 3;
    localparam int DL = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_div;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    grant;
    logic            issue_valid, issue_div;
    logic [TW-1:0]   issue_tag;
    logic            unit_busy, done_valid, done_div;
    logic [TW-1:0]   done_tag;
    logic [31:0]     perf_busy, perf_stall;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    muldiv_issue_sched #(
        .NUM_REQ(N), .TAG_W(TW), .MULT_LAT(ML), .DIV_LAT(DL)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_div(req_div), .req_tag(req_tag),
        .grant(grant), .issue_valid(issue_valid), .issue_div(issue_div), .issue_tag(issue_tag),
        .unit_busy(unit_busy), .done_valid(done_valid), .done_div(done_div), .done_tag(done_tag),
        .perf_busy(perf_busy), .perf_stall(perf_stall)
    );

    // Reference model: one in-flight op with an absolute completion cycle.
    int            cyc;
    bit            m_inflight;
    logic [TW-1:0] m_tag;
    bit            m_div;
    int            m_done_cyc;
    int            m_rr;
    longint        m_pbusy, m_pstall;

    logic [N-1:0]  e_grant;
    bit            e_iv, e_idiv, e_busy, e_dv, e_ddiv;
    logic [TW-1:0] e_itag, e_dtag;
    int            e_win;

    task automatic model_reset();
        m_inflight = 0; m_tag = '0; m_div = 0; m_done_cyc = 0;
        m_rr = 0; m_pbusy = 0; m_pstall = 0;
    endtask

    task automatic model_eval();
        bit running, at_done;
        running = m_inflight && (cyc < m_done_cyc);
        at_done = m_inflight && (cyc == m_done_cyc);
        e_busy  = running;
        e_dv    = at_done && !flush;
        e_dtag  = e_dv ? m_tag : '0;
        e_ddiv  = e_dv && m_div;
        e_grant = '0; e_iv = 0; e_idiv = 0; e_itag = '0; e_win = -1;
        if (!running && !flush)
            for (int k = 0; k < N; k++)
                if (e_win < 0 && 1'(req_valid >> ((m_rr + k) % N))) e_win = (m_rr + k) % N;
        if (e_win >= 0) begin
            e_iv    = 1;
            e_grant = N'(1) << e_win;
            e_idiv  = 1'(req_div >> e_win);
            e_itag  = TW'(req_tag >> (e_win * TW));
        end
    endtask

    task automatic model_commit();
        bit running, at_done;
        running = m_inflight && (cyc < m_done_cyc);
        at_done = m_inflight && (cyc == m_done_cyc);
        if (running) begin
            m_pbusy++;
            if (|req_valid) m_pstall++;
        end
        if (flush || at_done) m_inflight = 0;
        if (e_win >= 0) begin
            m_inflight = 1;
            m_tag      = e_itag;
            m_div      = e_idiv;
            m_done_cyc = cyc + (e_idiv ? DL : ML);
            m_rr       = (e_win + 1) % N;
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (DL + 2) begin
            settle();
            tick();
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit d, input int tag);
        req_valid = (req_valid & ~(N'(1) << i)) | (N'(v) << i);
        req_div   = (req_div & ~(N'(1) << i)) | (N'(d) << i);
        req_tag   = (req_tag & ~((N*TW)'({TW{1'b1}}) << (i * TW))) | ((N*TW)'(TW'(tag)) << (i * TW));
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        req_valid = '0; req_div = '0; req_tag = '0;
        #7;
        nchecks++;
        if ({grant, issue_valid, issue_div, issue_tag} !== '0) begin
            nerrors++; $display("FAIL reset_issue: got %b expected 0", {grant, issue_valid, issue_div, issue_tag});
        end
        nchecks++;
        if ({unit_busy, done_valid, done_div, done_tag} !== '0) begin
            nerrors++; $display("FAIL reset_done: got %b expected 0", {unit_busy, done_valid, done_div, done_tag});
        end
        nchecks++;
        if ({perf_busy, perf_stall} !== '0) begin
            nerrors++; $display("FAIL reset_perf: got %h expected 0", {perf_busy, perf_stall});
        end
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        bit           exp_dv;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 10 + i);
        for (int c = 0; c <= 12; c++) begin
            settle();
            exp_g  = (c % 3 == 0) ? N'(1) << ((c / 3) % 4) : '0;
            exp_dv = (c > 0) && (c % 3 == 0);
            nchecks++;
            if (grant !== exp_g) begin
                nerrors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, grant, exp_g);
            end
            nchecks++;
            if (done_valid !== exp_dv) begin
                nerrors++; $display("FAIL rr_done_valid c=%0d: got %b expected %b", c, done_valid, exp_dv);
            end
            if (exp_dv) begin
                nchecks++;
                if (done_tag !== TW'(10 + ((c / 3 - 1) % 4))) begin
                    nerrors++; $display("FAIL rr_done_tag c=%0d: got %0d expected %0d", c, done_tag, 10 + ((c / 3 - 1) % 4));
                end
            end
            tick();
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_single_mul();
        set_req(0, 1, 0, 7);
        settle();
        nchecks++;
        if ({grant, issue_valid, issue_div, issue_tag} !== {4'b0001, 1'b1, 1'b0, 5'd7}) begin
            nerrors++; $display("FAIL mul_issue: got %b expected %b", {grant, issue_valid, issue_div, issue_tag}, {4'b0001, 1'b1, 1'b0, 5'd7});
        end
        tick();
        set_req(0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            settle();
            nchecks++;
            if ({unit_busy, done_valid} !== 2'b10) begin
                nerrors++; $display("FAIL mul_busy k=%0d: got %b expected 10", k, {unit_busy, done_valid});
            end
            tick();
        end
        settle();
        nchecks++;
        if ({unit_busy, done_valid, done_div, done_tag} !== {1'b0, 1'b1, 1'b0, 5'd7}) begin
            nerrors++; $display("FAIL mul_done: got %b expected %b", {unit_busy, done_valid, done_div, done_tag}, {1'b0, 1'b1, 1'b0, 5'd7});
        end
        tick();
        drain();
    endtask

    task automatic test_divide_latency();
        set_req(0, 1, 0, 3);
        set_req(2, 1, 1, 9);
        settle();
        nchecks++;
        if ({grant, issue_div, issue_tag} !== {4'b0100, 1'b1, 5'd9}) begin
            nerrors++; $display("FAIL div_issue: got %b expected %b", {grant, issue_div, issue_tag}, {4'b0100, 1'b1, 5'd9});
        end
        tick();
        set_req(2, 0, 0, 0);
        for (int k = 1; k < DL; k++) begin
            settle();
            nchecks++;
            if ({unit_busy, done_valid, grant} !== {1'b1, 1'b0, 4'b0000}) begin
                nerrors++; $display("FAIL div_run k=%0d: got %b expected 1_0_0000", k, {unit_busy, done_valid, grant});
            end
            tick();
        end
        settle();
        nchecks++;
        if ({done_valid, done_div, done_tag} !== {1'b1, 1'b1, 5'd9}) begin
            nerrors++; $display("FAIL div_done: got %b expected %b", {done_valid, done_div, done_tag}, {1'b1, 1'b1, 5'd9});
        end
        nchecks++;
        if ({grant, issue_div, issue_tag} !== {4'b0001, 1'b0, 5'd3}) begin
            nerrors++; $display("FAIL div_b2b_issue: got %b expected %b", {grant, issue_div, issue_tag}, {4'b0001, 1'b0, 5'd3});
        end
        tick();
        set_req(0, 0, 0, 0);
        drain();
    endtask

    task automatic test_flush_run();
        set_req(3, 1, 1, 21);
        settle();
        nchecks++;
        if (grant !== 4'b1000) begin
            nerrors++; $display("FAIL flush_run_issue: got %b expected 1000", grant);
        end
        tick();
        set_req(3, 0, 0, 0);
        for (int k = 1; k < 5; k++) begin
            settle();
            tick();
        end
        flush = 1'b1;
        settle();
        nchecks++;
        if ({done_valid, grant, issue_valid} !== '0) begin
            nerrors++; $display("FAIL flush_run_cycle: got %b expected 0", {done_valid, grant, issue_valid});
        end
        tick();
        flush = 1'b0;
        settle();
        nchecks++;
        if (unit_busy !== 1'b0) begin
            nerrors++; $display("FAIL flush_run_idle: got %b expected 0", unit_busy);
        end
        for (int k = 0; k < DL + 2; k++) begin
            settle();
            nchecks++;
            if (done_valid !== 1'b0) begin
                nerrors++; $display("FAIL flush_run_ghost k=%0d: got %b expected 0", k, done_valid);
            end
            tick();
        end
        set_req(0, 1, 0, 4);
        set_req(1, 1, 0, 12);
        settle();
        nchecks++;
        if (grant !== 4'b0001) begin
            nerrors++; $display("FAIL flush_run_ptr: got %b expected 0001", grant);
        end
        tick();
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        drain();
    endtask

    task automatic test_flush_done();
        set_req(2, 1, 0, 6);
        settle();
        nchecks++;
        if (grant !== 4'b0100) begin
            nerrors++; $display("FAIL flush_done_issue: got %b expected 0100", grant);
        end
        tick();
        set_req(2, 0, 0, 0);
        set_req(1, 1, 0, 12);
        for (int k = 1; k <= 2; k++) begin
            settle();
            nchecks++;
            if (grant !== 4'b0000) begin
                nerrors++; $display("FAIL flush_done_hold k=%0d: got %b expected 0000", k, grant);
            end
            tick();
        end
        flush = 1'b1;
        settle();
        nchecks++;
        if ({done_valid, grant} !== 5'b0) begin
            nerrors++; $display("FAIL flush_done_cycle: got %b expected 00000", {done_valid, grant});
        end
        tick();
        flush = 1'b0;
        settle();
        nchecks++;
        if ({grant, issue_tag} !== {4'b0010, 5'd12}) begin
            nerrors++; $display("FAIL flush_done_regrant: got %b expected %b", {grant, issue_tag}, {4'b0010, 5'd12});
        end
        tick();
        set_req(1, 0, 0, 0);
        drain();
    endtask

    task automatic test_async_reset();
        set_req(2, 1, 1, 17);
        settle();
        nchecks++;
        if (grant !== 4'b0100) begin
            nerrors++; $display("FAIL areset_issue: got %b expected 0100", grant);
        end
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, i + 1);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        nchecks++;
        if ({grant, issue_valid, unit_busy, done_valid, done_div, done_tag} !== '0) begin
            nerrors++; $display("FAIL areset_outputs: got %b expected 0", {grant, issue_valid, unit_busy, done_valid, done_div, done_tag});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        settle();
        nchecks++;
        if (grant !== 4'b0001) begin
            nerrors++; $display("FAIL areset_ptr: got %b expected 0001", grant);
        end
        tick();
        req_valid = '0;
        for (int k = 0; k < DL + 2; k++) begin
            settle();
            nchecks++;
            if ({done_valid, done_tag} !== {e_dv, e_dtag} || (done_valid && done_tag == 5'd17)) begin
                nerrors++; $display("FAIL areset_done k=%0d: got %b expected %b", k, {done_valid, done_tag}, {e_dv, e_dtag});
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pb, exp_ps;
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            req_div   = N'($urandom);
            req_tag   = (N*TW)'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            settle();
            nchecks++;
            if ({grant, issue_valid, issue_div, issue_tag, unit_busy, done_valid, done_div, done_tag} !==
                {e_grant, e_iv, e_idiv, e_itag, e_busy, e_dv, e_ddiv, e_dtag}) begin
                nerrors++;
                $display("FAIL random c=%0d: got %b expected %b", c,
                         {grant, issue_valid, issue_div, issue_tag, unit_busy, done_valid, done_div, done_tag},
                         {e_grant, e_iv, e_idiv, e_itag, e_busy, e_dv, e_ddiv, e_dtag});
            end
            tick();
        end
        flush = 1'b0;
        req_valid = '0;
        drain();
`ifdef MULDIV_SCHED_PERF_EN
        exp_pb = 32'(m_pbusy);
        exp_ps = 32'(m_pstall);
`else
        exp_pb = '0;
        exp_ps = '0;
`endif
        nchecks++;
        if ({perf_busy, perf_stall} !== {exp_pb, exp_ps}) begin
            nerrors++; $display("FAIL perf: got %0d/%0d expected %0d/%0d", perf_busy, perf_stall, exp_pb, exp_ps);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_mul();
        test_divide_latency();
        test_flush_run();
        test_flush_done();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
